// File: rtl/diff_serial_tx.sv
// diff_serial_tx: differential-encoding serial transmitter (XNOR line code).
// A word accepted on valid/ready goes out LSB first as start, data,
// optional parity, stop. A data 1 holds the line level and a 0 toggles it.
// Ports: clk, reset (sync, active-high), data_in[WIDTH], valid -> ready,
//   line_out (registered line), busy (frame active), done (stop cycle).
// Optional feature: define DIFF_TX_PARITY_EN to add an even-parity bit.
module diff_serial_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid,
   output logic             ready,
   output logic             line_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef DIFF_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } state_t;
`endif

   state_t           state_q, state_d;
   logic             line_q, line_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef DIFF_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   // The line register is loaded with the level of the *next* cycle,
   // so every state computes the symbol shown in the following cycle.
   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
`ifdef DIFF_TX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (valid) begin
               shift_d = data_in;
               cnt_d   = '0;
               line_d  = ~line_q;
               state_d = S_START;
`ifdef DIFF_TX_PARITY_EN
               par_d   = ^data_in;
`endif
            end
         end
         S_START: begin
            line_d  = shift_q[0] ? line_q : ~line_q;
            shift_d = shift_q >> 1;
            state_d = S_DATA;
         end
         S_DATA: begin
            if (cnt_q == LAST) begin
`ifdef DIFF_TX_PARITY_EN
               line_d  = par_q ? line_q : ~line_q;
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end else begin
               line_d  = shift_q[0] ? line_q : ~line_q;
               shift_d = shift_q >> 1;
               cnt_d   = cnt_q + CW'(1);
            end
         end
`ifdef DIFF_TX_PARITY_EN
         S_PARITY: begin
            state_d = S_STOP;
         end
`endif
         S_STOP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         line_q  <= 1'b1;
         shift_q <= '0;
         cnt_q   <= '0;
`ifdef DIFF_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
`ifdef DIFF_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign ready    = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_STOP);
   assign line_out = line_q;

endmodule

// File: doc/diff_serial_tx.md
Name: diff_serial_tx

Overview:
- Differential-encoding serial transmitter, the transmit end of the XNOR-detected line code used by the team's comparator/decoder blocks.
- Accepts a parallel word on a valid/ready handshake and serialises it LSB first.
- Encoding: a data 1 holds the line level; a data 0 toggles it. A receiver recovers each bit as XNOR of consecutive line samples.
- Frame: start marker, data bits, optional parity bit, stop marker.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to transmit; sampled only on an accepted handshake.
- valid  input  1  data_in holds a word to send.
- ready  output  1  block is idle and can accept a word.
- line_out  output  1  encoded serial line (registered).
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse during the stop-marker cycle.

Behaviour:
- Clocking and reset: single clock domain, clk only. Reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values, from the edge where reset is sampled high: state=IDLE, line_out=1, ready=1, busy=0, done=0, bit counter=0, shift register=0. Reset overrides all other activity, including a frame in progress. After reset the line holds at 1 with no glitch.
- Handshake: a word is accepted on a rising edge where valid=1 and ready=1. The block captures data_in into the shift register and moves to START.
  - ready=1 only in IDLE; valid is ignored in every other state.
  - data_in may change freely after acceptance.
- Encoding rule: each cycle, line_next = bit ? line_cur : ~line_cur.
- States:
  - IDLE: line_out holds its last level (encodes 1s). ready=1, busy=0.
  - START: one cycle; line_out toggles (encodes 0). busy=1.
  - DATA: WIDTH cycles; the shift register LSB is encoded and then shifted right. The counter runs 0..WIDTH-1 and exits to PARITY (macro defined) or STOP when the counter reaches WIDTH-1.
  - PARITY: present only with the macro; see Optional Feature.
  - STOP: one cycle; line_out holds (encodes 1). done=1. Next state is IDLE.
- Timing: for acceptance at edge k, line_out shows START during cycle k+1, data bit i during cycle k+2+i, and STOP during cycle k+WIDTH+2 (shifted +1 with parity). ready is high again in cycle k+WIDTH+3.
- Frame length is WIDTH+2 cycles, or WIDTH+3 with parity.
- No back-to-back accept inside STOP. The minimum gap between frames is one IDLE cycle.
- The idle level after a frame is whatever level STOP left on the line; it is not forced back to 1.
- Counter width is clog2(WIDTH). The counter is cleared on acceptance and never wraps mid-frame.

Optional Feature:
- Macro: DIFF_TX_PARITY_EN.
- Defined: after the DATA state, a PARITY state lasts one cycle and encodes even parity (XOR of all captured data bits), using the same hold/toggle rule. The parity is computed from the word captured at acceptance.
- Undefined: the PARITY state, the parity register and the parity logic are absent; DATA goes directly to STOP.

Test Plan:
- Reset, then valid=1, data_in=8'hA5 accepted at edge k -> line_out from cycle k+1: 0 (start), then 0,1,1,0,1,1,0,0, then 0 (stop, done=1); ready=1 at k+11.
- data_in=8'hFF -> start 0, data 0×8, stop 0; a single transition on the whole frame.
- data_in=8'h00 -> start 0, data 1,0,1,0,1,0,1,0, stop 0; receiver-side XNOR of consecutive samples recovers 00000000.
- valid held high across two frames with data 8'h3C then 8'hC3 -> second word accepted only when ready rises (one IDLE cycle after done); changing data_in during busy has no effect on the line.
- Assert reset during data bit 4 of the 8'hA5 frame -> next cycle line_out=1, ready=1, busy=0, done=0; a new word 8'h01 then sends the correct frame.
- With DIFF_TX_PARITY_EN defined, 8'hA5 (parity 0) -> data as in the first scenario, then parity toggle to 1, stop 1, done at k+11, ready at k+12.
